// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - tick-paced async-serial transmitter with valid/ready word input
module uart_tx #(
    parameter int N             = 8,
    parameter int TICKS_PER_BIT = 1,
    parameter int STOP_BITS     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic         tx,
    output logic         busy
);

    localparam int BW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   shift_reg, shift_n;
    logic [BW-1:0]  bit_count, bit_n;
    logic [7:0]     tick_count, tick_n;
    logic           tx_n;
    logic           bit_end;

    assign o_ready = (state == IDLE);
    assign busy    = !o_ready;
    assign bit_end = tick && (tick_count == 8'(TICKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_count  <= '0;
            tick_count <= '0;
            tx         <= 1'b1;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_count  <= bit_n;
            tick_count <= tick_n;
            tx         <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        bit_n   = bit_count;
        tick_n  = tick_count;
        case (state)
            IDLE: begin
                // Ticks are ignored here; a tick on the accept edge is dropped by the clear.
                if (i_valid) begin
                    shift_n = i_data;
                    bit_n   = '0;
                    tick_n  = '0;
                    state_n = START;
                end
            end
            default: begin
                if (bit_end) begin
                    tick_n = '0;
                    case (state)
                        START: begin
                            state_n = DATA;
                            bit_n   = '0;
                        end
                        DATA: begin
                            shift_n = shift_reg >> 1;
                            if (bit_count == BW'(N - 1)) begin
                                state_n = STOP;
                                bit_n   = '0;
                            end else begin
                                bit_n = bit_count + 1'b1;
                            end
                        end
                        default: begin
                            if (bit_count == BW'(STOP_BITS - 1)) begin
                                state_n = IDLE;
                                bit_n   = '0;
                            end else begin
                                bit_n = bit_count + 1'b1;
                            end
                        end
                    endcase
                end else if (tick) begin
                    tick_n = tick_count + 8'd1;
                end
            end
        endcase
    end

    // tx is derived from the next state so the line changes on the same edge as the state.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] i_data;
    logic       valid1, valid3;
    logic       ready1, ready3;
    logic       tx1, tx3;
    logic       busy1, busy3;

    int n_assert;
    int n_fail;
    int period;
    int tcnt;

    uart_tx #(.N(8), .TICKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .i_data(i_data), .i_valid(valid1),
        .o_ready(ready1), .tx(tx1), .busy(busy1)
    );

    uart_tx #(.N(8), .TICKS_PER_BIT(3), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .tick(tick), .i_data(i_data), .i_valid(valid3),
        .o_ready(ready3), .tx(tx3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic txv(input bit sel);
        return sel ? tx3 : tx1;
    endfunction

    function automatic logic busyv(input bit sel);
        return sel ? busy3 : busy1;
    endfunction

    function automatic logic readyv(input bit sel);
        return sel ? ready3 : ready1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; tick pulses once every `period` cycles.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % period;
        tick = (tcnt == 0);
    endtask

    // Called in the first START cycle; walks every cycle of the frame then checks the idle cycle.
    task automatic check_frame(input bit sel, input logic [15:0] data, input int nbits,
                               input int nstop, input int tpb, input string tag);
        int   len0;
        int   len;
        logic eb;
        len0 = ((period - tcnt) % period) + (tpb - 1) * period + 1;
        for (int i = 0; i < 1 + nbits + nstop; i++) begin
            if (i == 0)          eb = 1'b0;
            else if (i <= nbits) eb = data[i-1];
            else                 eb = 1'b1;
            len = (i == 0) ? len0 : period * tpb;
            for (int c = 0; c < len; c++) begin
                chk($sformatf("%s_tx_bit%0d_cyc%0d", tag, i, c), 16'(txv(sel)), 16'(eb));
                chk($sformatf("%s_busy_bit%0d_cyc%0d", tag, i, c), 16'(busyv(sel)), 16'd1);
                next_cycle();
            end
        end
        chk({tag, "_idle_busy"}, 16'(busyv(sel)), 16'd0);
        chk({tag, "_idle_tx"}, 16'(txv(sel)), 16'd1);
        chk({tag, "_idle_ready"}, 16'(readyv(sel)), 16'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        period   = 4;
        tcnt     = 1;
        rst      = 1'b0;
        tick     = 1'b0;
        i_data   = 8'h00;
        valid1   = 1'b0;
        valid3   = 1'b0;

        // Asynchronous reset before the first clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_tx1", 16'(tx1), 16'd1);
        chk("rst_ready1", 16'(ready1), 16'd1);
        chk("rst_busy1", 16'(busy1), 16'd0);
        chk("rst_tx3", 16'(tx3), 16'd1);
        chk("rst_ready3", 16'(ready3), 16'd1);
        chk("rst_busy3", 16'(busy3), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single frame 0xA5, tick every 4 clocks
        period = 4; tcnt = 1; tick = 1'b0;
        i_data = 8'hA5; valid1 = 1'b1;
        next_cycle();
        valid1 = 1'b0;
        check_frame(1'b0, 16'h00A5, 8, 1, 1, "a5");

        // Oversampled: 3 ticks per bit, tick every 2 clocks, two stop bits
        period = 2; tcnt = 1; tick = 1'b0;
        i_data = 8'h00; valid3 = 1'b1;
        next_cycle();
        valid3 = 1'b0;
        check_frame(1'b1, 16'h0000, 8, 2, 3, "ovs");

        // Handshake blocking: i_valid held, i_data changes mid-frame
        period = 4; tcnt = 1; tick = 1'b0;
        i_data = 8'h3C; valid1 = 1'b1;
        next_cycle();
        i_data = 8'hFF;
        check_frame(1'b0, 16'h003C, 8, 1, 1, "hs1");
        next_cycle();
        valid1 = 1'b0;
        check_frame(1'b0, 16'h00FF, 8, 1, 1, "hs2");

        // Tick on the accept edge is not counted
        period = 4; tcnt = 0; tick = 1'b1;
        i_data = 8'hC3; valid1 = 1'b1;
        next_cycle();
        valid1 = 1'b0;
        chk("coinc_start_tx", 16'(tx1), 16'd0);
        chk("coinc_start_busy", 16'(busy1), 16'd1);
        check_frame(1'b0, 16'h00C3, 8, 1, 1, "coinc");

        // Reset in the middle of data bit 3 of 0x55
        period = 4; tcnt = 3; tick = 1'b0;
        i_data = 8'h55; valid1 = 1'b1;
        next_cycle();
        valid1 = 1'b0;
        repeat (14) next_cycle();
        chk("mid_tx_before_rst", 16'(tx1), 16'd0);
        chk("mid_busy_before_rst", 16'(busy1), 16'd1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 16'(tx1), 16'd1);
        chk("mid_rst_ready", 16'(ready1), 16'd1);
        chk("mid_rst_busy", 16'(busy1), 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        period = 4; tcnt = 1; tick = 1'b0;
        i_data = 8'h81; valid1 = 1'b1;
        next_cycle();
        valid1 = 1'b0;
        check_frame(1'b0, 16'h0081, 8, 1, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
